// File: rtl/count_uart_tx.sv
// 8N1 UART transmitter for latched oscillator counts.
// Samples are buffered in a small FIFO and sent back-to-back with one idle cycle between frames.
module count_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic [7:0] sample_data,
  input  logic       overflow_clr,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [PW:0]   DEPTH_C   = (PW + 1)'(DEPTH);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [7:0]    shift_r, shift_s;
  logic [CW-1:0] baud_r, baud_s;
  logic [2:0]    bit_r, bit_s;
  logic          tx_r, tx_s;
  logic          pop_s;

  logic [7:0]    mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r, wr_ptr_s;
  logic [PW-1:0] rd_ptr_r, rd_ptr_s;
  logic [PW:0]   count_r, count_s;
  logic          push_s;
  logic          drop_s;
  logic          overflow_r, overflow_s;
  logic          busy_r, busy_s;
  logic          full_r, full_s;

  // Transmit FSM next-state and next tx level; tx is registered from these values.
  always_comb begin
    state_s = state_r;
    shift_s = shift_r;
    baud_s  = baud_r;
    bit_s   = bit_r;
    tx_s    = tx_r;
    pop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (count_r != '0) begin
          pop_s   = 1'b1;
          shift_s = mem_r[rd_ptr_r];
          baud_s  = '0;
          bit_s   = 3'd0;
          state_s = START;
          tx_s    = 1'b0;
        end else begin
          state_s = IDLE;
          tx_s    = 1'b1;
        end
      end
      START: begin
        if (baud_r == BAUD_LAST) begin
          baud_s  = '0;
          bit_s   = 3'd0;
          state_s = DATA;
          tx_s    = shift_r[0];
        end else begin
          baud_s = baud_r + CW'(1);
          tx_s   = 1'b0;
        end
      end
      DATA: begin
        if (baud_r == BAUD_LAST) begin
          baud_s  = '0;
          shift_s = {1'b0, shift_r[7:1]};
          bit_s   = bit_r + 3'd1;
          // The next bit is shift_r[1] because the shift lands on this same edge.
          if (bit_r == 3'd7) begin
            state_s = STOP;
            tx_s    = 1'b1;
          end else begin
            state_s = DATA;
            tx_s    = shift_r[1];
          end
        end else begin
          baud_s = baud_r + CW'(1);
          tx_s   = shift_r[0];
        end
      end
      STOP: begin
        if (baud_r == BAUD_LAST) begin
          baud_s  = '0;
          state_s = IDLE;
        end else begin
          baud_s = baud_r + CW'(1);
        end
        tx_s = 1'b1;
      end
      default: begin
        state_s = IDLE;
        baud_s  = '0;
        bit_s   = 3'd0;
        tx_s    = 1'b1;
      end
    endcase
  end

  // FIFO bookkeeping, overflow flag and status outputs.
  always_comb begin
    push_s   = sample_valid && ((count_r != DEPTH_C) || pop_s);
    drop_s   = sample_valid && !push_s;
    wr_ptr_s = push_s ? (wr_ptr_r + PW'(1)) : wr_ptr_r;
    rd_ptr_s = pop_s  ? (rd_ptr_r + PW'(1)) : rd_ptr_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + (PW + 1)'(1);
      2'b01:   count_s = count_r - (PW + 1)'(1);
      default: count_s = count_r;
    endcase
    if (drop_s) begin
      overflow_s = 1'b1;
    end else if (overflow_clr) begin
      overflow_s = 1'b0;
    end else begin
      overflow_s = overflow_r;
    end
    busy_s = (state_s != IDLE) || (count_s != '0);
    full_s = (count_s == DEPTH_C);
  end

  // FSM and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      shift_r    <= 8'h00;
      baud_r     <= '0;
      bit_r      <= 3'd0;
      tx_r       <= 1'b1;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
      busy_r     <= 1'b0;
      full_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      shift_r    <= shift_s;
      baud_r     <= baud_s;
      bit_r      <= bit_s;
      tx_r       <= tx_s;
      wr_ptr_r   <= wr_ptr_s;
      rd_ptr_r   <= rd_ptr_s;
      count_r    <= count_s;
      overflow_r <= overflow_s;
      busy_r     <= busy_s;
      full_r     <= full_s;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= sample_data;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  assign tx        = tx_r;
  assign busy      = busy_r;
  assign fifo_full = full_r;
  assign overflow  = overflow_r;

endmodule
